// File: rtl/rwc_rsp_eval.sv
// rwc_rsp_eval: evaluation stage behind the read-write collision generator.
// Takes one challenge, runs the generator NUM_REP times, and counts per bit
// how often the posedge and negedge responses disagreed. A majority vote over
// those counts gives the response word. A unanimity mask and a timeout error
// flag are returned with it.
module rwc_rsp_eval #(
  parameter int NUM_REP = 8,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        w_resetn,
  input  logic        cha_valid,
  output logic        cha_ready,
  input  logic [9:0]  cha_addr,
  input  logic [31:0] cha_data,
  output logic        gen_enable,
  output logic [9:0]  gen_cha_addr,
  output logic [31:0] gen_cha_data,
  input  logic        gen_available,
  input  logic [31:0] gen_rsp_pos,
  input  logic [31:0] gen_rsp_neg,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] rsp_mask,
  output logic        rsp_err
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LAUNCH, ST_WAIT_BUSY, ST_WAIT_DONE,
    ST_SETTLE, ST_ACCUM, ST_VOTE, ST_OUTPUT
  } state_t;

  localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [7:0] REP_LAST    = 8'(NUM_REP);
  localparam logic [8:0] REP_CMP     = 9'(NUM_REP);

  state_t      state_reg, state_next;
  logic [7:0]  timer_reg, timer_next;
  logic [7:0]  rep_reg, rep_next;
  logic [7:0]  rep_inc;
  logic        err_reg, err_next;
  logic        accept;
  logic        accum_en;
  logic [31:0] sample;
  logic [31:0] vote_data;
  logic [31:0] vote_mask;
  logic [9:0]  cha_addr_reg;
  logic [31:0] cha_data_reg;
  logic        rsp_valid_reg;
  logic [31:0] rsp_data_reg;
  logic [31:0] rsp_mask_reg;
  logic        rsp_err_reg;

  assign rep_inc      = rep_reg + 8'd1;
  assign sample       = gen_rsp_pos ^ gen_rsp_neg;
  assign cha_ready    = (state_reg == ST_IDLE);
  assign gen_cha_addr = cha_addr_reg;
  assign gen_cha_data = cha_data_reg;
  assign rsp_valid    = rsp_valid_reg;
  assign rsp_data     = rsp_data_reg;
  assign rsp_mask     = rsp_mask_reg;
  assign rsp_err      = rsp_err_reg;

  // State, wait timer, run counter and error flag registers.
  always_ff @(posedge clk) begin
    if (!w_resetn) begin
      state_reg <= ST_IDLE;
      timer_reg <= '0;
      rep_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      rep_reg   <= rep_next;
      err_reg   <= err_next;
    end
  end

  // Next-state logic; the launch pulse is combinational so it lasts exactly the LAUNCH cycle.
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    rep_next   = rep_reg;
    err_next   = err_reg;
    gen_enable = 1'b0;
    accept     = 1'b0;
    accum_en   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cha_valid) begin
          accept     = 1'b1;
          rep_next   = '0;
          state_next = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (gen_available) begin
          gen_enable = 1'b1;
          timer_next = '0;
          state_next = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (!gen_available) begin
          timer_next = '0;
          state_next = ST_WAIT_DONE;
        end else if (timer_reg == TMO_LAST) begin
          err_next   = 1'b1;
          state_next = ST_VOTE;
        end else begin
          timer_next = timer_reg + 8'd1;
        end
      end
      ST_WAIT_DONE: begin
        if (gen_available) begin
          timer_next = '0;
          state_next = ST_SETTLE;
        end else if (timer_reg == TMO_LAST) begin
          err_next   = 1'b1;
          state_next = ST_VOTE;
        end else begin
          timer_next = timer_reg + 8'd1;
        end
      end
      ST_SETTLE: begin
        if (timer_reg == SETTLE_LAST) begin
          timer_next = '0;
          state_next = ST_ACCUM;
        end else begin
          timer_next = timer_reg + 8'd1;
        end
      end
      ST_ACCUM: begin
        accum_en   = 1'b1;
        rep_next   = rep_inc;
        state_next = (rep_inc == REP_LAST) ? ST_VOTE : ST_LAUNCH;
      end
      ST_VOTE: begin
        state_next = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (rsp_ready) begin
          err_next   = 1'b0;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Challenge latch; held for the whole evaluation.
  always_ff @(posedge clk) begin
    if (!w_resetn) begin
      cha_addr_reg <= '0;
      cha_data_reg <= '0;
    end else if (accept) begin
      cha_addr_reg <= cha_addr;
      cha_data_reg <= cha_data;
    end
  end

  // One collision counter per response bit, with its vote decision.
  for (genvar gi = 0; gi < 32; gi++) begin : g_bit
    logic [7:0] cnt_reg;
    logic [8:0] cnt_x2;

    // Count runs in which this bit collided.
    always_ff @(posedge clk) begin
      if (!w_resetn || accept) begin
        cnt_reg <= '0;
      end else if (accum_en) begin
        cnt_reg <= cnt_reg + {7'd0, sample[gi]};
      end
    end

    assign cnt_x2        = {cnt_reg, 1'b0};
    assign vote_data[gi] = (cnt_x2 > REP_CMP);
    assign vote_mask[gi] = (cnt_reg == 8'd0) || (cnt_reg == REP_LAST);
  end

  // Response register: loaded in VOTE, held until the consumer takes it.
  always_ff @(posedge clk) begin
    if (!w_resetn) begin
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_mask_reg  <= '0;
      rsp_err_reg   <= 1'b0;
    end else if (state_reg == ST_VOTE) begin
      rsp_valid_reg <= 1'b1;
      rsp_data_reg  <= err_reg ? 32'd0 : vote_data;
      rsp_mask_reg  <= err_reg ? 32'd0 : vote_mask;
      rsp_err_reg   <= err_reg;
    end else if (state_reg == ST_OUTPUT && rsp_ready) begin
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_mask_reg  <= '0;
      rsp_err_reg   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rwc_rsp_eval.sv
// Testbench for rwc_rsp_eval: behavioural generator model, table vectors,
// randomized challenges against a counting reference, timeout and reset cases.
module tb_rwc_rsp_eval;
  localparam int NUM_REP = 8;
  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        w_resetn;
  logic        cha_valid;
  logic        cha_ready;
  logic [9:0]  cha_addr;
  logic [31:0] cha_data;
  logic        gen_enable;
  logic [9:0]  gen_cha_addr;
  logic [31:0] gen_cha_data;
  logic        gen_available;
  logic [31:0] gen_rsp_pos;
  logic [31:0] gen_rsp_neg;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [31:0] rsp_mask;
  logic        rsp_err;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int en_total = 0;
  int en_last = 0;
  logic gen_stuck = 1'b0;
  logic [31:0] pat_q[$];

  typedef logic [NUM_REP-1:0][31:0] pats_t;
  typedef struct {
    pats_t       pats;
    logic [31:0] exp_data;
    logic [31:0] exp_mask;
  } vec_t;
  vec_t tbl[6];

  rwc_rsp_eval #(.NUM_REP(NUM_REP), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .w_resetn(w_resetn),
    .cha_valid(cha_valid), .cha_ready(cha_ready),
    .cha_addr(cha_addr), .cha_data(cha_data),
    .gen_enable(gen_enable), .gen_cha_addr(gen_cha_addr), .gen_cha_data(gen_cha_data),
    .gen_available(gen_available), .gen_rsp_pos(gen_rsp_pos), .gen_rsp_neg(gen_rsp_neg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_mask(rsp_mask), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Cycle counter and launch-pulse counter, sampled mid-cycle.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (gen_enable) begin
      en_total = en_total + 1;
      en_last  = cyc;
    end
  end

  // Generator model: idle -> launched -> busy -> result -> idle.
  initial begin
    gen_available = 1'b1;
    gen_rsp_pos   = '0;
    gen_rsp_neg   = '0;
    forever begin
      @(negedge clk);
      if (gen_enable && !gen_stuck) begin
        logic [31:0] pat;
        logic [31:0] pos;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        gen_available = 1'b0;
        pat = (pat_q.size() > 0) ? pat_q.pop_front() : 32'd0;
        pos = $urandom;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        gen_rsp_pos   = pos;
        gen_rsp_neg   = pos ^ pat;
        gen_available = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: majority vote over the per-run collision words.
  function automatic void ref_vote(input pats_t pats, output logic [31:0] d, output logic [31:0] m);
    for (int b = 0; b < 32; b++) begin
      int c;
      c = 0;
      for (int r = 0; r < NUM_REP; r++) c = c + int'(pats[r][b]);
      d[b] = (2 * c > NUM_REP);
      m[b] = (c == 0) || (c == NUM_REP);
    end
  endfunction

  // One full challenge/response transaction, optionally stalling the response.
  task automatic run_txn(input pats_t pats, input logic [9:0] a, input logic [31:0] d, input int stall,
                         output logic [31:0] od, output logic [31:0] om, output logic oe,
                         output int en_cnt, output int lat);
    int  en0;
    bit  got;
    pat_q.delete();
    for (int r = 0; r < NUM_REP; r++) pat_q.push_back(pats[r]);
    od = '0; om = '0; oe = 1'b0; lat = 0;
    @(negedge clk); #1;
    check("cha_ready_idle", 32'(cha_ready), 32'd1);
    en0 = en_total;
    cha_valid = 1'b1; cha_addr = a; cha_data = d;
    @(negedge clk); #1;
    cha_valid = 1'b0; cha_addr = 10'($urandom); cha_data = $urandom;
    check("cha_ready_busy", 32'(cha_ready), 32'd0);
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    check("rsp_valid_arrives", 32'(got), 32'd1);
    od = rsp_data; om = rsp_mask; oe = rsp_err; lat = cyc - en_last;
    check("gen_cha_addr", 32'(gen_cha_addr), 32'(a));
    check("gen_cha_data", gen_cha_data, d);
    for (int s = 0; s < stall; s++) begin
      cha_valid = (s < 3);
      @(negedge clk); #1;
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_data", rsp_data, od);
      check("stall_mask", rsp_mask, om);
      check("stall_cha_ready", 32'(cha_ready), 32'd0);
    end
    cha_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check("cha_ready_back", 32'(cha_ready), 32'd1);
    en_cnt = en_total - en0;
    $display("txn addr=%h data=%h -> rsp=%h mask=%h err=%0d launches=%0d", a, d, od, om, oe, en_cnt);
  endtask

  initial begin
    logic [31:0] od, om, ed, em;
    logic        oe;
    int          en, lat;
    pats_t       p;

    tbl[0] = '{{NUM_REP{32'h000000FF}}, 32'h000000FF, 32'hFFFFFFFF};
    tbl[1] = '{{{4{32'hFFFF0000}}, {4{32'h00000000}}}, 32'h00000000, 32'h0000FFFF};
    tbl[2] = '{{{5{32'h00000001}}, {3{32'h00000000}}}, 32'h00000001, 32'hFFFFFFFE};
    tbl[3] = '{'0, 32'h00000000, 32'hFFFFFFFF};
    tbl[4] = '{{32'hFFFFFFFF, {7{32'h00000000}}}, 32'h00000000, 32'h00000000};
    tbl[5] = '{{{7{32'hA5A5A5A5}}, 32'h0000FFFF}, 32'hA5A5A5A5, 32'h5A5AA5A5};

    w_resetn = 1'b0; cha_valid = 1'b0; rsp_ready = 1'b0; cha_addr = '0; cha_data = '0;
    repeat (3) @(negedge clk);
    w_resetn = 1'b1;

    // Reset state, held over idle cycles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("rst_cha_ready", 32'(cha_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_gen_enable", 32'(gen_enable), 32'd0);
      check("rst_gen_cha_data", gen_cha_data, 32'd0);
      check("rst_gen_cha_addr", 32'(gen_cha_addr), 32'd0);
    end

    // Table-driven vectors; the first one also exercises a 10-cycle stall.
    for (int i = 0; i < 6; i++) begin
      run_txn(tbl[i].pats, 10'(i * 37 + 5), $urandom, (i == 0) ? 10 : 0, od, om, oe, en, lat);
      check($sformatf("tbl%0d_data", i), od, tbl[i].exp_data);
      check($sformatf("tbl%0d_mask", i), om, tbl[i].exp_mask);
      check($sformatf("tbl%0d_err", i), 32'(oe), 32'd0);
      check($sformatf("tbl%0d_launches", i), 32'(en), 32'(NUM_REP));
    end

    // Randomized challenges against the counting reference.
    for (int k = 0; k < 20; k++) begin
      logic [31:0] base;
      base = $urandom;
      for (int r = 0; r < NUM_REP; r++) p[r] = base ^ ($urandom & $urandom);
      ref_vote(p, ed, em);
      run_txn(p, 10'($urandom), $urandom, int'($urandom_range(0, 3)), od, om, oe, en, lat);
      check($sformatf("rnd%0d_data", k), od, ed);
      check($sformatf("rnd%0d_mask", k), om, em);
      check($sformatf("rnd%0d_err", k), 32'(oe), 32'd0);
      check($sformatf("rnd%0d_launches", k), 32'(en), 32'(NUM_REP));
    end

    // Generator never goes busy: timeout error with zeroed response.
    gen_stuck = 1'b1;
    run_txn({NUM_REP{32'hFFFFFFFF}}, 10'h3AA, 32'hDEADBEEF, 0, od, om, oe, en, lat);
    gen_stuck = 1'b0;
    check("tmo_err", 32'(oe), 32'd1);
    check("tmo_data", od, 32'd0);
    check("tmo_mask", om, 32'd0);
    check("tmo_launches", 32'(en), 32'd1);
    check("tmo_latency_in_range", 32'(lat >= TIMEOUT && lat <= TIMEOUT + 3), 32'd1);

    // Error flag must not leak into the next transaction.
    run_txn(tbl[0].pats, 10'h011, 32'h12345678, 0, od, om, oe, en, lat);
    check("post_tmo_err", 32'(oe), 32'd0);
    check("post_tmo_data", od, 32'h000000FF);

    // Reset while accumulating the first run: back to idle, no response.
    begin
      bit saw_low, saw_rise, saw_valid;
      int en0;
      pat_q.delete();
      for (int r = 0; r < NUM_REP; r++) pat_q.push_back($urandom);
      @(negedge clk); #1;
      cha_valid = 1'b1; cha_addr = 10'h155; cha_data = 32'hCAFEF00D;
      @(negedge clk); #1;
      cha_valid = 1'b0;
      saw_low = 1'b0; saw_rise = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (!gen_available) saw_low = 1'b1;
        else if (saw_low) begin
          saw_rise = 1'b1;
          break;
        end
        @(negedge clk); #1;
      end
      check("rst_mid_gen_return", 32'(saw_rise), 32'd1);
      repeat (3) @(negedge clk);
      #1 w_resetn = 1'b0;
      @(negedge clk); #1;
      w_resetn = 1'b1;
      check("rst_mid_cha_ready", 32'(cha_ready), 32'd1);
      check("rst_mid_gen_cha_data", gen_cha_data, 32'd0);
      en0 = en_total;
      saw_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk); #1;
        if (rsp_valid) saw_valid = 1'b1;
      end
      check("rst_mid_no_rsp", 32'(saw_valid), 32'd0);
      check("rst_mid_no_launch", 32'(en_total - en0), 32'd0);
      pat_q.delete();
      $display("txn reset-during-accum: idle=%0d rsp_seen=%0d", cha_ready, saw_valid);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
